// File: rtl/byte_pkg.sv
// Shared types and limits for the byte memory responder.
package byte_pkg;

   typedef enum logic {IDLE, WAIT} byte_resp_state_t;

   localparam int unsigned BYTE_MAX_WAIT = 15;

endpackage

// File: rtl/byte_mem_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
module byte_mem_array #(
   parameter int unsigned DATA_BYTE = 4,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_we,
   input  logic                       i_re,
   input  logic [DATA_BYTE-1:0]       i_mask,
   input  logic [$clog2(DEPTH)-1:0]   i_idx,
   input  logic [DATA_BYTE*8-1:0]     i_wdata,
   output logic [DATA_BYTE*8-1:0]     o_rdata
);

   logic [DATA_BYTE*8-1:0] r_mem [DEPTH];
   logic [DATA_BYTE*8-1:0] r_rdata;

   // Storage is deliberately left unreset so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int unsigned b = 0; b < DATA_BYTE; b++) begin
            if (i_mask[b]) begin
               r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_mem_responder.sv
// Byte memory interface responder: masked writes, registered reads, optional
// fixed wait states per access signalled through hold_o.
module byte_mem_responder
   import byte_pkg::*;
#(
   parameter int unsigned DATA_BYTE   = 4,
   parameter int unsigned ADDR_SIZE   = 32,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic                   isWrite_i,
   input  logic [DATA_BYTE-1:0]   writeMask_i,
   input  logic [ADDR_SIZE-1:0]   addr_i,
   input  logic [DATA_BYTE*8-1:0] writeData_i,
   output logic [DATA_BYTE*8-1:0] readData_o,
   output logic                   hold_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned OFF_W = $clog2(DATA_BYTE);
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("byte_mem_responder: DEPTH must be a power of two and at least 2");
   end
   if (WAIT_STATES > BYTE_MAX_WAIT) begin : g_chk_wait
      $error("byte_mem_responder: WAIT_STATES exceeds BYTE_MAX_WAIT");
   end

   byte_resp_state_t r_state;
   logic [3:0]       r_cnt;
   logic             w_hold;
   logic             w_accept;
   logic             w_we;
   logic             w_re;
   logic [IDX_W-1:0] w_idx;

   // Offset and upper address bits drop out, so words alias modulo DEPTH.
   assign w_idx = IDX_W'(addr_i >> OFF_W);

   always_comb begin
      w_hold = 1'b0;
      case (r_state)
         IDLE:    w_hold = (WS != 4'd0) && enable_i;
         WAIT:    w_hold = enable_i && (r_cnt != WS);
         default: w_hold = 1'b0;
      endcase
   end

   assign hold_o   = w_hold;
   assign w_accept = enable_i && !w_hold;
   assign w_we     = w_accept && isWrite_i && !rst_i;
   assign w_re     = w_accept && !isWrite_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (enable_i && (WS != 4'd0)) begin
                  r_state <= WAIT;
                  r_cnt   <= 4'd1;
               end
            end
            WAIT: begin
               // A dropped enable mid-wait abandons the request without access.
               if (!enable_i || (r_cnt == WS)) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   byte_mem_array #(
      .DATA_BYTE (DATA_BYTE),
      .DEPTH     (DEPTH)
   ) u_array (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_mask  (writeMask_i),
      .i_idx   (w_idx),
      .i_wdata (writeData_i),
      .o_rdata (readData_o)
   );

endmodule

// File: tb/tb_byte_mem_responder.sv
// Directed bench for byte_mem_responder at WAIT_STATES of 0, 2 and 3.
module tb_byte_mem_responder;

   logic        clk;
   logic        rst;
   logic        en   [3];
   logic        wr   [3];
   logic [3:0]  msk  [3];
   logic [31:0] addr [3];
   logic [31:0] wd   [3];
   logic [31:0] rd   [3];
   logic        hold [3];

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        en;
      logic        we;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_hold;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vt [14];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   byte_mem_responder #(.DATA_BYTE(4), .ADDR_SIZE(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
      .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .isWrite_i(wr[0]), .writeMask_i(msk[0]),
      .addr_i(addr[0]), .writeData_i(wd[0]), .readData_o(rd[0]), .hold_o(hold[0]));

   byte_mem_responder #(.DATA_BYTE(4), .ADDR_SIZE(32), .DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
      .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .isWrite_i(wr[1]), .writeMask_i(msk[1]),
      .addr_i(addr[1]), .writeData_i(wd[1]), .readData_o(rd[1]), .hold_o(hold[1]));

   byte_mem_responder #(.DATA_BYTE(4), .ADDR_SIZE(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
      .clk_i(clk), .rst_i(rst), .enable_i(en[2]), .isWrite_i(wr[2]), .writeMask_i(msk[2]),
      .addr_i(addr[2]), .writeData_i(wd[2]), .readData_o(rd[2]), .hold_o(hold[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Holds a request until accepted, counting hold cycles; ends just after the accept edge.
   task automatic access(input int k, input logic w, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] d, input int exp_wait, input logic chk_prev,
                         input logic [31:0] prev, input string nm);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      en[k] = 1'b1; wr[k] = w; msk[k] = m; addr[k] = a; wd[k] = d;
      while (!done) begin
         #1;
         if (hold[k]) begin
            if (chk_prev) chk({nm, " stable"}, rd[k], prev);
            n++;
            @(posedge clk); #1;
            if (n > 40) begin
               chk({nm, " timeout"}, 32'(n), 32'(exp_wait));
               done = 1'b1;
            end
         end else begin
            @(posedge clk); #1;
            done = 1'b1;
         end
      end
      en[k] = 1'b0;
      chk({nm, " holds"}, 32'(n), 32'(exp_wait));
   endtask

   initial begin
      vt[0]  = '{1'b1, 1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      vt[1]  = '{1'b1, 1'b1, 4'b0001, 32'h0000_0010, 32'h0000_00AA, 1'b0, 32'h0000_0000};
      vt[2]  = '{1'b1, 1'b0, 4'hF,    32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEAA};
      vt[3]  = '{1'b0, 1'b0, 4'hF,    32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEAA};
      vt[4]  = '{1'b1, 1'b1, 4'hF,    32'h0000_1004, 32'h0000_0055, 1'b0, 32'hDEAD_BEAA};
      vt[5]  = '{1'b1, 1'b0, 4'hF,    32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_0055};
      vt[6]  = '{1'b1, 1'b0, 4'hF,    32'h0000_1006, 32'h0000_0000, 1'b0, 32'h0000_0055};
      vt[7]  = '{1'b1, 1'b1, 4'h0,    32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 32'h0000_0055};
      vt[8]  = '{1'b1, 1'b0, 4'hF,    32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEAA};
      vt[9]  = '{1'b1, 1'b1, 4'hF,    32'h0000_0008, 32'hAABB_CCDD, 1'b0, 32'hDEAD_BEAA};
      vt[10] = '{1'b1, 1'b1, 4'b1010, 32'h0000_0008, 32'h1122_3344, 1'b0, 32'hDEAD_BEAA};
      vt[11] = '{1'b1, 1'b0, 4'hF,    32'h0000_000B, 32'h0000_0000, 1'b0, 32'h11BB_33DD};
      vt[12] = '{1'b1, 1'b1, 4'hF,    32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h11BB_33DD};
      vt[13] = '{1'b1, 1'b0, 4'hF,    32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         en[k] = 1'b0; wr[k] = 1'b0; msk[k] = 4'h0; addr[k] = '0; wd[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset: nothing held, read data stays at its reset value.
      for (int c = 0; c < 10; c++) begin
         #1;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("idle hold u%0d c%0d", k, c), 32'(hold[k]), 32'h0);
            chk($sformatf("idle rd u%0d c%0d", k, c), rd[k], 32'h0);
         end
         @(posedge clk); #1;
      end

      // Zero-wait table on u_ws0: hold before the edge, read data after it.
      for (int i = 0; i < 14; i++) begin
         en[0] = vt[i].en; wr[0] = vt[i].we; msk[0] = vt[i].mask;
         addr[0] = vt[i].addr; wd[0] = vt[i].wdata;
         #1;
         chk($sformatf("ws0 row%0d hold", i), 32'(hold[0]), 32'(vt[i].exp_hold));
         @(posedge clk); #1;
         chk($sformatf("ws0 row%0d rd", i), rd[0], vt[i].exp_rd);
      end
      en[0] = 1'b0;

      // Three wait states: preload then read with enable held.
      access(2, 1'b1, 4'hF, 32'h20, 32'h1234_5678, 3, 1'b0, '0, "ws3 preload");
      access(2, 1'b0, 4'hF, 32'h20, 32'h0, 3, 1'b0, '0, "ws3 read");
      chk("ws3 read data", rd[2], 32'h1234_5678);

      // Two wait states, back-to-back reads; first data must hold during second's waits.
      access(1, 1'b1, 4'hF, 32'h40, 32'hA1A2_A3A4, 2, 1'b0, '0, "ws2 wr40");
      access(1, 1'b1, 4'hF, 32'h44, 32'hB1B2_B3B4, 2, 1'b0, '0, "ws2 wr44");
      access(1, 1'b0, 4'hF, 32'h40, 32'h0, 2, 1'b0, '0, "ws2 rd40");
      chk("ws2 rd40 data", rd[1], 32'hA1A2_A3A4);
      access(1, 1'b0, 4'hF, 32'h44, 32'h0, 2, 1'b1, 32'hA1A2_A3A4, "ws2 rd44");
      chk("ws2 rd44 data", rd[1], 32'hB1B2_B3B4);

      // Write aborted by dropping enable after one hold cycle.
      access(2, 1'b1, 4'hF, 32'h30, 32'h0BAD_F00D, 3, 1'b0, '0, "ws3 wr30");
      en[2] = 1'b1; wr[2] = 1'b1; msk[2] = 4'hF; addr[2] = 32'h30; wd[2] = 32'hFFFF_FFFF;
      #1 chk("abort first hold", 32'(hold[2]), 32'h1);
      @(posedge clk); #1;
      en[2] = 1'b0;
      #1 chk("abort dropped hold", 32'(hold[2]), 32'h0);
      @(posedge clk); #1;
      access(2, 1'b0, 4'hF, 32'h30, 32'h0, 3, 1'b0, '0, "abort reread");
      chk("abort reread data", rd[2], 32'h0BAD_F00D);

      // Write whose accept cycle coincides with reset.
      en[2] = 1'b1; wr[2] = 1'b1; msk[2] = 4'hF; addr[2] = 32'h30; wd[2] = 32'hFFFF_FFFF;
      for (int c = 0; c < 3; c++) begin
         #1 chk($sformatf("rstacc hold c%0d", c), 32'(hold[2]), 32'h1);
         @(posedge clk); #1;
      end
      #1 chk("rstacc accept hold", 32'(hold[2]), 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      en[2] = 1'b0;
      chk("rstacc rd cleared", rd[2], 32'h0);
      access(2, 1'b0, 4'hF, 32'h30, 32'h0, 3, 1'b0, '0, "rstacc reread");
      chk("rstacc reread data", rd[2], 32'h0BAD_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
